ysyx_25030093_mem_arbiter: RTL and testbench
============================================

# ysyx_25030093_mem_arbiter

Two-master, one-slave memory arbiter between the IFU (instruction fetch, master 0) and the LSU (load/store, master 1) in front of the single shared memory port. It accepts one transaction at a time and grants round-robin when both masters request. It holds the grant through the request and response phases. A slave that goes silent is converted into an error response by a timeout counter.

## Interface
Parameters:
- TIMEOUT, 255, max cycles waited for a slave response before error (≥2)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_req_valid / m0_req_ready  in / out  1  IFU request handshake
- m0_req_addr  in  32  IFU address (read only; IFU never writes)
- m0_resp_valid / m0_resp_ready  out / in  1  IFU response handshake
- m0_resp_rdata  out  32  read data
- m0_resp_err  out  1  1 = timeout error
- m1_req_valid / m1_req_ready  in / out  1  LSU request handshake
- m1_req_addr, m1_req_wdata  in  32  LSU address, write data
- m1_req_wen  in  1  1 = write
- m1_req_wmask  in  4  byte strobes
- m1_resp_valid / m1_resp_ready  out / in  1  LSU response handshake
- m1_resp_rdata  out  32  read data
- m1_resp_err  out  1  1 = timeout error
- s_req_valid / s_req_ready  out / in  1  request to memory
- s_req_addr, s_req_wdata  out  32  latched request payload
- s_req_wen  out  1  latched write enable
- s_req_wmask  out  4  latched byte strobes
- s_resp_valid / s_resp_ready  in / out  1  response from memory
- s_resp_rdata  in  32  memory read data
- stray_resp  out  1  sticky flag: slave response arrived outside WAIT_RESP

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, RESP.
  - Registers: owner (1b), last (1b), payload regs, rdata/err regs, timeout counter (8b minimum, sized for TIMEOUT).
- IDLE: winner = the only valid master. If both are valid, winner = !last.
  - mX_req_ready = (state==IDLE) & winner==X & mX_req_valid.
  - On handshake: latch addr/wdata/wen/wmask and set owner=X.
  - For m0: wen=0, wmask=4'b0000, wdata=0.
  - Next state: REQ.
- REQ: s_req_valid=1 with latched payload. On s_req_ready: clear counter and go to WAIT_RESP.
- WAIT_RESP: s_resp_ready=1; counter increments each cycle.
  - On s_resp_valid: capture rdata, err=0, go to RESP.
  - If counter==TIMEOUT-1 with no s_resp_valid: rdata=0, err=1, go to RESP.
  - s_resp_valid takes precedence over timeout in the same cycle.
- RESP: m[owner]_resp_valid=1 with captured rdata/err; the other master's resp_valid=0.
  - On owner's resp_ready: last=owner, go to IDLE.
- s_resp_ready=1 in IDLE, REQ and RESP as well. Responses there are discarded and set stray_resp (cleared only by reset).
- Write transactions also wait for a slave response (write ack); rdata is don't-care and is passed through.
- Unused mX_resp_rdata/err outputs are driven from the shared capture regs. Only resp_valid is per-master.

## Timing
- Reset (reset=0, async):
  - state=IDLE, owner=0, last=1 (IFU wins first tie), counter=0, stray_resp=0, all payload/rdata/err regs = 0.
  - While reset=0, all valid and ready outputs are 0, including m*_req_ready and s_resp_ready.
- Minimum latency with a zero-wait slave: accept cycle N (IDLE) → s_req_valid N+1 → slave accepts N+1 → response accepted N+2 → mX_resp_valid N+3. Back to IDLE at N+4 if resp_ready=1.
- One outstanding transaction. The non-owner's req_ready stays 0 until return to IDLE.
- A new request is not accepted in the same cycle the response completes. IDLE always lasts ≥1 cycle.
- Reset asserted mid-transaction: the transaction is abandoned and the FSM goes immediately to IDLE. The late slave response counts as stray.
- Payload outputs are stable from REQ entry until the s_req handshake. Requesters may change their inputs freely after their own req handshake.

## Test plan
- Single IFU read 0x8000_0000, slave returns 0x0000_0413 with zero wait → m0_resp_valid 3 cycles after accept, rdata=0x0000_0413, err=0, m1 untouched.
- Both valid continuously after reset → grants alternate IFU, LSU, IFU, LSU; no master is granted twice in a row while the other is waiting.
- LSU write addr 0x8000_0100, wdata 0xDEADBEEF, wmask 4'b0011 → s_req_* carries exactly those values; s_req_valid held across 3 cycles of s_req_ready=0.
- Slave never responds, TIMEOUT=8 → m1_resp_valid with err=1, rdata=0 exactly 8 cycles after entering WAIT_RESP. A later slave response sets stray_resp=1.
- m0_resp_ready held 0 for 5 cycles → resp_valid and rdata stay stable; m1 request pending is not accepted until IDLE.
- reset pulsed low during WAIT_RESP → all outputs 0 immediately; after release the next tie goes to IFU.

Source files
------------

// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Bus bundle between the two requesters (IFU = m0, LSU = m1), the arbiter
// and the shared memory port. The arbiter sits on the "slave" modport (it is
// the slave of both CPU masters); the surrounding system/bench uses "master".
interface ysyx_25030093_mem_arbiter_if;
  logic        m0_req_valid;
  logic        m0_req_ready;
  logic [31:0] m0_req_addr;
  logic        m0_resp_valid;
  logic        m0_resp_ready;
  logic [31:0] m0_resp_rdata;
  logic        m0_resp_err;

  logic        m1_req_valid;
  logic        m1_req_ready;
  logic [31:0] m1_req_addr;
  logic [31:0] m1_req_wdata;
  logic        m1_req_wen;
  logic [3:0]  m1_req_wmask;
  logic        m1_resp_valid;
  logic        m1_resp_ready;
  logic [31:0] m1_resp_rdata;
  logic        m1_resp_err;

  logic        s_req_valid;
  logic        s_req_ready;
  logic [31:0] s_req_addr;
  logic [31:0] s_req_wdata;
  logic        s_req_wen;
  logic [3:0]  s_req_wmask;
  logic        s_resp_valid;
  logic        s_resp_ready;
  logic [31:0] s_resp_rdata;

  modport slave (
    input  m0_req_valid, m0_req_addr, m0_resp_ready,
    input  m1_req_valid, m1_req_addr, m1_req_wdata, m1_req_wen, m1_req_wmask, m1_resp_ready,
    input  s_req_ready, s_resp_valid, s_resp_rdata,
    output m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
    output m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
    output s_req_valid, s_req_addr, s_req_wdata, s_req_wen, s_req_wmask, s_resp_ready
  );

  modport master (
    output m0_req_valid, m0_req_addr, m0_resp_ready,
    output m1_req_valid, m1_req_addr, m1_req_wdata, m1_req_wen, m1_req_wmask, m1_resp_ready,
    output s_req_ready, s_resp_valid, s_resp_rdata,
    input  m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
    input  m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
    input  s_req_valid, s_req_addr, s_req_wdata, s_req_wen, s_req_wmask, s_resp_ready
  );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master / one-slave memory arbiter. One transaction in flight, round-robin
// on ties, grant held through request and response phases, and a silent slave
// is turned into an error response after TIMEOUT cycles in WAIT_RESP.
module ysyx_25030093_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_25030093_mem_arbiter_if.slave  bus,
  output logic                        stray_resp
);
  // Counter must hold TIMEOUT-1; never narrower than 8 bits.
  localparam int CW_RAW = $clog2(TIMEOUT);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_owner;
  logic          r_last;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_wen;
  logic [3:0]    r_wmask;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          r_stray;

  logic w_winner;
  logic w_grant0;
  logic w_grant1;
  logic w_owner_ready;

  // Arbitration, next-state and handshake outputs. Every valid/ready is
  // qualified with reset so nothing handshakes while reset is held low.
  always_comb begin
    w_state_next      = r_state;
    w_winner          = 1'b0;
    w_grant0          = 1'b0;
    w_grant1          = 1'b0;
    w_owner_ready     = r_owner ? bus.m1_resp_ready : bus.m0_resp_ready;
    bus.m0_req_ready  = 1'b0;
    bus.m1_req_ready  = 1'b0;
    bus.s_req_valid   = 1'b0;
    bus.m0_resp_valid = 1'b0;
    bus.m1_resp_valid = 1'b0;
    bus.s_resp_ready  = reset;

    if (bus.m0_req_valid && bus.m1_req_valid) begin
      w_winner = ~r_last;
    end else begin
      w_winner = bus.m1_req_valid;
    end

    case (r_state)
      IDLE: begin
        w_grant0 = reset && !w_winner && bus.m0_req_valid;
        w_grant1 = reset &&  w_winner && bus.m1_req_valid;
        bus.m0_req_ready = w_grant0;
        bus.m1_req_ready = w_grant1;
        if (w_grant0 || w_grant1) w_state_next = REQ;
      end
      REQ: begin
        bus.s_req_valid = reset;
        if (bus.s_req_ready) w_state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.s_resp_valid || (r_cnt == CNT_LAST)) w_state_next = RESP;
      end
      RESP: begin
        bus.m0_resp_valid = reset && !r_owner;
        bus.m1_resp_valid = reset &&  r_owner;
        if (w_owner_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Latch owner and payload on the accept handshake; IFU requests are reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wen   <= 1'b0;
      r_wmask <= 4'h0;
    end else if (w_grant1) begin
      r_owner <= 1'b1;
      r_addr  <= bus.m1_req_addr;
      r_wdata <= bus.m1_req_wdata;
      r_wen   <= bus.m1_req_wen;
      r_wmask <= bus.m1_req_wmask;
    end else if (w_grant0) begin
      r_owner <= 1'b0;
      r_addr  <= bus.m0_req_addr;
      r_wdata <= 32'h0;
      r_wen   <= 1'b0;
      r_wmask <= 4'h0;
    end
  end

  // Capture the slave response, or synthesize an error on timeout; a real
  // response wins over a timeout landing in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (r_state == WAIT_RESP) begin
      if (bus.s_resp_valid) begin
        r_rdata <= bus.s_resp_rdata;
        r_err   <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  // Remember who was served last so ties alternate; IFU wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                r_last <= 1'b1;
    else if (r_state == RESP && w_owner_ready) r_last <= r_owner;
  end

  // Timeout counter: cleared when the slave takes the request, counts in WAIT_RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   r_cnt <= '0;
    else if (r_state == REQ && bus.s_req_ready)   r_cnt <= '0;
    else if (r_state == WAIT_RESP)                r_cnt <= r_cnt + 1'b1;
  end

  // Sticky flag for slave responses arriving when none is expected.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        r_stray <= 1'b0;
    else if (bus.s_resp_valid && r_state != WAIT_RESP) r_stray <= 1'b1;
  end

  assign bus.s_req_addr    = r_addr;
  assign bus.s_req_wdata   = r_wdata;
  assign bus.s_req_wen     = r_wen;
  assign bus.s_req_wmask   = r_wmask;
  assign bus.m0_resp_rdata = r_rdata;
  assign bus.m0_resp_err   = r_err;
  assign bus.m1_resp_rdata = r_rdata;
  assign bus.m1_resp_err   = r_err;
  assign stray_resp        = r_stray;
endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed requests, a behavioural slave
// and a scoreboard of expected responses checked by an independent monitor.
module tb_ysyx_25030093_mem_arbiter;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stray_resp;

  ysyx_25030093_mem_arbiter_if bus();

  ysyx_25030093_mem_arbiter #(.TIMEOUT(TO)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .stray_resp (stray_resp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // slave controls (written by main only) and slave observations (slave only)
  int          slv_stall  = 0;
  logic        slv_silent = 1'b0;
  int          stray_req  = 0;
  logic [31:0] cap_addr   = 32'h0;
  logic [31:0] cap_wdata  = 32'h0;
  logic        cap_wen    = 1'b0;
  logic [3:0]  cap_wmask  = 4'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // memory contents the slave returns for reads
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: slave_rd = 32'h0000_0413;
      32'h8000_0004: slave_rd = 32'h0010_0093;
      32'h8000_0008: slave_rd = 32'h0020_0113;
      32'h8000_0200: slave_rd = 32'hCAFE_0001;
      32'h8000_0204: slave_rd = 32'hCAFE_0002;
      32'h8000_0010: slave_rd = 32'h1111_2222;
      32'h8000_0014: slave_rd = 32'h3333_4444;
      32'h8000_0020: slave_rd = 32'h5555_6666;
      32'h8000_0028: slave_rd = 32'h7777_8888;
      default:       slave_rd = 32'hBAD0_0000;
    endcase
  endfunction

  // behavioural zero-wait slave with optional request stall and silent mode
  initial begin : slave
    int          stall_left;
    logic        in_req;
    logic        pend;
    logic [31:0] pend_data;
    int          stray_done;
    stall_left = 0; in_req = 1'b0; pend = 1'b0; pend_data = 32'h0; stray_done = 0;
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b0;
    bus.s_resp_rdata = 32'h0;
    forever begin
      @(negedge clock);
      bus.s_resp_valid = 1'b0;
      if (stray_done != stray_req) begin
        bus.s_resp_valid = 1'b1;
        bus.s_resp_rdata = 32'h5757_5757;
        stray_done++;
      end else if (pend) begin
        bus.s_resp_valid = 1'b1;
        bus.s_resp_rdata = pend_data;
        pend = 1'b0;
      end
      bus.s_req_ready = 1'b0;
      if (bus.s_req_valid) begin
        if (!in_req) begin
          in_req = 1'b1;
          stall_left = slv_stall;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.s_req_ready = 1'b1;
          in_req    = 1'b0;
          cap_addr  = bus.s_req_addr;
          cap_wdata = bus.s_req_wdata;
          cap_wen   = bus.s_req_wen;
          cap_wmask = bus.s_req_wmask;
          if (!slv_silent) begin
            pend = 1'b1;
            pend_data = bus.s_req_wen ? 32'h0000_00AC : slave_rd(bus.s_req_addr);
          end
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  task automatic check_resp(input logic m, input logic [31:0] rdata, input logic err);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL resp_unexpected: m%0d rdata=%h err=%0d, expected no response", m, rdata, err);
    end else begin
      e = sb.pop_front();
      if (e.m !== m || e.rdata !== rdata || e.err !== err ||
          (bus.m0_resp_valid && bus.m1_resp_valid)) begin
        n_fail++;
        $display("[TB] FAIL resp: got m%0d rdata=%h err=%0d both=%0d, expected m%0d rdata=%h err=%0d",
                 m, rdata, err, bus.m0_resp_valid && bus.m1_resp_valid, e.m, e.rdata, e.err);
      end else begin
        $display("[TB] resp m%0d rdata=%h err=%0d ok", m, rdata, err);
      end
    end
  endtask

  // monitor: compares every completed response handshake against the scoreboard
  initial begin : monitor
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        if (bus.m0_resp_valid && bus.m0_resp_ready) check_resp(1'b0, bus.m0_resp_rdata, bus.m0_resp_err);
        if (bus.m1_resp_valid && bus.m1_resp_ready) check_resp(1'b1, bus.m1_resp_rdata, bus.m1_resp_err);
      end
    end
  end

  task automatic drive_m0(input logic [31:0] a);
    bus.m0_req_addr  = a;
    bus.m0_req_valid = 1'b1;
  endtask

  task automatic drive_m1(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic [3:0] wm);
    bus.m1_req_addr  = a;
    bus.m1_req_wdata = wd;
    bus.m1_req_wen   = we;
    bus.m1_req_wmask = wm;
    bus.m1_req_valid = 1'b1;
  endtask

  // wait (bounded) for master m to be accepted; push its expected response
  task automatic wait_accept(input logic m, input logic [31:0] er, input logic ee, output int waited);
    logic ok;
    ok = 1'b0;
    waited = -1;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (m ? bus.m1_req_ready : bus.m0_req_ready) begin
        ok = 1'b1;
        waited = k;
        sb.push_back('{m, er, ee});
        $display("[TB] req m%0d accepted", m);
        @(posedge clock);
        #1;
        if (m) bus.m1_req_valid = 1'b0;
        else   bus.m0_req_valid = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: m%0d never accepted, expected accept", m);
      bus.m0_req_valid = 1'b0;
      bus.m1_req_valid = 1'b0;
    end
  endtask

  // count negedges after the accept edge until master m shows resp_valid
  task automatic wait_resp(input logic m, output int cyc);
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      #2;
      cyc++;
      if (m ? bus.m1_resp_valid : bus.m0_resp_valid) break;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
      #3;
    end
    chk(name, 128'(sb.size()), 128'd0);
  endtask

  logic [31:0] rr_a0 [4] = '{32'h8000_0004, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008};
  logic [31:0] rr_d0 [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0010_0093, 32'h0020_0113};
  logic [31:0] rr_a1 [4] = '{32'h8000_0200, 32'h8000_0204, 32'h8000_0200, 32'h8000_0204};
  logic [31:0] rr_d1 [4] = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0002};

  initial begin : main
    int order [4];
    int g, i0, i1, w, cyc;
    g = 0; i0 = 0; i1 = 0; w = 0; cyc = 0;
    for (int k = 0; k < 4; k++) order[k] = -1;
    bus.m0_req_valid = 1'b0; bus.m0_req_addr = 32'h0; bus.m0_resp_ready = 1'b1;
    bus.m1_req_valid = 1'b0; bus.m1_req_addr = 32'h0; bus.m1_req_wdata = 32'h0;
    bus.m1_req_wen = 1'b0; bus.m1_req_wmask = 4'h0; bus.m1_resp_ready = 1'b1;

    // reset state with both masters requesting
    repeat (3) @(negedge clock);
    bus.m0_req_valid = 1'b1;
    bus.m1_req_valid = 1'b1;
    #2;
    chk("rst_handshakes", {bus.m0_req_ready, bus.m1_req_ready, bus.s_req_valid, bus.s_resp_ready,
                           bus.m0_resp_valid, bus.m1_resp_valid, stray_resp}, 128'd0);
    chk("rst_payload", {bus.s_req_addr, bus.s_req_wdata, bus.s_req_wen, bus.s_req_wmask,
                        bus.m0_resp_rdata, bus.m0_resp_err}, 128'd0);

    // both valid continuously: grants must alternate IFU, LSU, IFU, LSU
    @(negedge clock);
    reset = 1'b1;
    for (int cyc_rr = 0; cyc_rr < 100 && g < 4; cyc_rr++) begin
      bus.m0_req_addr = rr_a0[i0];
      bus.m1_req_addr = rr_a1[i1];
      bus.m1_req_wen  = 1'b0;
      bus.m0_req_valid = 1'b1;
      bus.m1_req_valid = 1'b1;
      #1;
      if (bus.m0_req_ready) begin
        order[g] = 0;
        sb.push_back('{1'b0, rr_d0[i0], 1'b0});
        if (i0 < 3) i0++;
        g++;
      end else if (bus.m1_req_ready) begin
        order[g] = 1;
        sb.push_back('{1'b1, rr_d1[i1], 1'b0});
        if (i1 < 3) i1++;
        g++;
      end
      if (g == 4) begin
        @(posedge clock);
        #1;
        bus.m0_req_valid = 1'b0;
        bus.m1_req_valid = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), 128'(order[k]), 128'(k % 2));
    drain("rr_drain");

    // single IFU read, zero-wait slave
    @(negedge clock);
    drive_m0(32'h8000_0000);
    wait_accept(1'b0, 32'h0000_0413, 1'b0, w);
    wait_resp(1'b0, cyc);
    chk("ifu_latency", 128'(cyc), 128'd3);
    chk("ifu_m1_quiet", {bus.m1_resp_valid, bus.m1_req_ready}, 128'd0);
    drain("ifu_drain");

    // LSU write with the slave stalling s_req_ready for 3 cycles
    slv_stall = 3;
    @(negedge clock);
    drive_m1(32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 4'b0011);
    wait_accept(1'b1, 32'h0000_00AC, 1'b0, w);
    bus.m1_req_addr = 32'h0; bus.m1_req_wdata = 32'h0; bus.m1_req_wen = 1'b0; bus.m1_req_wmask = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #2;
      chk($sformatf("wr_hold%0d", k),
          {bus.s_req_valid, bus.s_req_ready, bus.s_req_addr, bus.s_req_wdata, bus.s_req_wen, bus.s_req_wmask},
          {1'b1, 1'b0, 32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 4'b0011});
    end
    drain("wr_drain");
    chk("wr_slave_seen", {cap_addr, cap_wdata, cap_wen, cap_wmask},
        {32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 4'b0011});
    slv_stall = 0;

    // silent slave: timeout error TO cycles after entering WAIT_RESP
    slv_silent = 1'b1;
    @(negedge clock);
    drive_m1(32'h8000_0300, 32'h0, 1'b0, 4'h0);
    wait_accept(1'b1, 32'h0, 1'b1, w);
    wait_resp(1'b1, cyc);
    chk("to_latency", 128'(cyc), 128'(2 + TO));
    chk("to_no_stray_yet", 128'(stray_resp), 128'd0);
    drain("to_drain");
    slv_silent = 1'b0;
    stray_req++;
    repeat (3) @(negedge clock);
    #2;
    chk("to_stray_set", 128'(stray_resp), 128'd1);

    // IFU response back-pressured; pending LSU request waits for IDLE
    bus.m0_resp_ready = 1'b0;
    @(negedge clock);
    drive_m0(32'h8000_0010);
    wait_accept(1'b0, 32'h1111_2222, 1'b0, w);
    drive_m1(32'h8000_0014, 32'h0, 1'b0, 4'h0);
    wait_resp(1'b0, cyc);
    chk("stall_latency", 128'(cyc), 128'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      #2;
      chk($sformatf("stall_hold%0d", k),
          {bus.m0_resp_valid, bus.m0_resp_rdata, bus.m0_resp_err, bus.m1_req_ready, bus.m1_resp_valid},
          {1'b1, 32'h1111_2222, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clock);
    bus.m0_resp_ready = 1'b1;
    #1;
    chk("stall_no_overlap", 128'(bus.m1_req_ready), 128'd0);
    wait_accept(1'b1, 32'h3333_4444, 1'b0, w);
    chk("m1_after_idle", 128'(w), 128'd1);
    drain("stall_drain");

    // IFU read so that, without reset, the next tie would go to the LSU
    @(negedge clock);
    drive_m0(32'h8000_0020);
    wait_accept(1'b0, 32'h5555_6666, 1'b0, w);
    drain("pre_rst_drain");

    // reset pulsed during WAIT_RESP of an LSU read
    slv_silent = 1'b1;
    @(negedge clock);
    drive_m1(32'h8000_0024, 32'h0, 1'b0, 4'h0);
    wait_accept(1'b1, 32'h0, 1'b1, w);
    repeat (3) @(negedge clock);
    drive_m0(32'h8000_0028);
    drive_m1(32'h8000_0024, 32'h0, 1'b0, 4'h0);
    reset = 1'b0;
    #1;
    chk("midrst_outputs", {bus.m0_req_ready, bus.m1_req_ready, bus.s_req_valid, bus.s_resp_ready,
                           bus.m0_resp_valid, bus.m1_resp_valid, stray_resp}, 128'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    slv_silent = 1'b0;
    #1;
    chk("post_rst_tie", {bus.m0_req_ready, bus.m1_req_ready}, 128'b10);
    bus.m1_req_valid = 1'b0;
    wait_accept(1'b0, 32'h7777_8888, 1'b0, w);
    drain("post_rst_drain");
    stray_req++;
    repeat (3) @(negedge clock);
    #2;
    chk("late_stray", 128'(stray_resp), 128'd1);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
